// File: rtl/up_bus_responder.sv
// up_bus_responder: byte-serial uP handshake slave that issues register read/write strobes.
// Define UP_INPUT_SYNC_EN to pass uP_start, uP_handshake_1 and uP_data_out through two-flop synchronisers.
module up_bus_responder #(
    parameter int NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        uP_start,
    input  logic        uP_handshake_1,
    input  logic [7:0]  uP_data_out,
    output logic        uP_handshake_2,
    output logic [7:0]  uP_data_in,
    output logic        uP_ack,
    output logic [7:0]  reg_address,
    output logic [31:0] reg_write_data,
    output logic        reg_write,
    output logic        reg_read,
    input  logic [31:0] reg_read_data
);
    typedef enum logic [3:0] {
        IDLE, RX_WAIT_H1, RX_WAIT_H1_LOW, EXECUTE, READ_WAIT,
        TX_LOAD, TX_WAIT_H1, TX_WAIT_H1_LOW, ACK
    } state_t;

    state_t      state_q;
    logic        start_s, h1_s;
    logic [7:0]  data_s;
    logic        hs2_q, ack_q, wr_q, rd_q;
    logic [7:0]  din_q, addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  idx_q, rem_q;
    logic [47:0] rx_q;
    logic [39:0] tx_q;
    logic        cmd_ok, addr_ok, is_rd, go;
    logic [7:0]  status;

`ifdef UP_INPUT_SYNC_EN
    logic [9:0] sync1_q, sync2_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {uP_start, uP_handshake_1, uP_data_out};
            sync2_q <= sync1_q;
        end
    end
    assign {start_s, h1_s, data_s} = sync2_q;
`else
    assign {start_s, h1_s, data_s} = {uP_start, uP_handshake_1, uP_data_out};
`endif

    // rx_q shifts bytes in from the top: [7:0]=command, [15:8]=register, [47:16]=data
    assign cmd_ok  = rx_q[7:1] == 7'd0;
    assign is_rd   = rx_q[0];
    assign addr_ok = {1'b0, rx_q[15:8]} < 9'(NUM_REGS);
    assign go      = cmd_ok && addr_ok;
    assign status  = !cmd_ok ? 8'h01 : !addr_ok ? 8'h02 : 8'h00;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            hs2_q   <= 1'b0;
            ack_q   <= 1'b0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            din_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            idx_q   <= '0;
            rem_q   <= '0;
            rx_q    <= '0;
            tx_q    <= '0;
        end else begin
            wr_q <= 1'b0;
            rd_q <= 1'b0;
            if (!start_s && state_q != IDLE && state_q != ACK) begin
                state_q <= IDLE;
                hs2_q   <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: if (start_s) begin
                        state_q <= RX_WAIT_H1;
                        idx_q   <= '0;
                    end
                    RX_WAIT_H1: if (h1_s) begin
                        rx_q    <= {data_s, rx_q[47:8]};
                        hs2_q   <= 1'b1;
                        state_q <= RX_WAIT_H1_LOW;
                    end
                    RX_WAIT_H1_LOW: if (!h1_s) begin
                        hs2_q   <= 1'b0;
                        idx_q   <= idx_q + 3'd1;
                        state_q <= (idx_q == 3'd5) ? EXECUTE : RX_WAIT_H1;
                        // strobes are registered here so they are high during EXECUTE
                        if (idx_q == 3'd5) begin
                            addr_q <= rx_q[15:8];
                            wr_q   <= go && !is_rd;
                            rd_q   <= go && is_rd;
                            if (go && !is_rd) wdata_q <= rx_q[47:16];
                        end
                    end
                    EXECUTE: begin
                        tx_q    <= {32'h0, status};
                        rem_q   <= 3'd1;
                        state_q <= (go && is_rd) ? READ_WAIT : TX_LOAD;
                    end
                    READ_WAIT: begin
                        tx_q    <= {8'h00, reg_read_data};
                        rem_q   <= 3'd5;
                        state_q <= TX_LOAD;
                    end
                    TX_LOAD: begin
                        din_q   <= tx_q[7:0];
                        tx_q    <= {8'h00, tx_q[39:8]};
                        rem_q   <= rem_q - 3'd1;
                        state_q <= TX_WAIT_H1;
                    end
                    TX_WAIT_H1: if (!hs2_q) begin
                        hs2_q <= 1'b1;
                    end else if (h1_s) begin
                        hs2_q   <= 1'b0;
                        state_q <= TX_WAIT_H1_LOW;
                    end
                    TX_WAIT_H1_LOW: if (!h1_s) begin
                        state_q <= (rem_q == 3'd0) ? ACK : TX_LOAD;
                        ack_q   <= rem_q == 3'd0;
                    end
                    ACK: if (!start_s) begin
                        ack_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign uP_handshake_2 = hs2_q;
    assign uP_data_in     = din_q;
    assign uP_ack         = ack_q;
    assign reg_address    = addr_q;
    assign reg_write_data = wdata_q;
    assign reg_write      = wr_q;
    assign reg_read       = rd_q;
endmodule

// File: tb/tb_up_bus_responder.sv
// tb_up_bus_responder: table-driven uP transactions plus abort and mid-reply reset sequences.
module tb_up_bus_responder;
`ifdef UP_INPUT_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic [7:0]  cmd;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [31:0] rval;
        int          nwr;
        int          nrd;
        int          nbytes;
        logic [39:0] reply;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        uP_start = 1'b0;
    logic        uP_handshake_1 = 1'b0;
    logic [7:0]  uP_data_out = '0;
    logic        uP_handshake_2;
    logic [7:0]  uP_data_in;
    logic        uP_ack;
    logic [7:0]  reg_address;
    logic [31:0] reg_write_data;
    logic        reg_write;
    logic        reg_read;
    logic [31:0] reg_read_data = 32'hDEADBEEF;

    int          n_chk = 0;
    int          n_fail = 0;
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    logic [7:0]  last_addr = '0;
    logic [31:0] last_wdata = '0;
    logic [31:0] rd_val = '0;
    logic        rd_seen;
    vec_t        vecs[8];

    up_bus_responder #(.NUM_REGS(32)) dut (
        .clk(clk), .reset(reset), .uP_start(uP_start), .uP_handshake_1(uP_handshake_1),
        .uP_data_out(uP_data_out), .uP_handshake_2(uP_handshake_2), .uP_data_in(uP_data_in),
        .uP_ack(uP_ack), .reg_address(reg_address), .reg_write_data(reg_write_data),
        .reg_write(reg_write), .reg_read(reg_read), .reg_read_data(reg_read_data)
    );

    always #10 clk = ~clk;

    // register-file model: read data is valid only in the cycle after reg_read
    always @(posedge clk) begin
        rd_seen = reg_read;
        if (reg_write) begin
            wr_cnt++;
            last_addr  = reg_address;
            last_wdata = reg_write_data;
        end
        if (reg_read) begin
            rd_cnt++;
            last_addr = reg_address;
        end
        #1 reg_read_data = rd_seen ? rd_val : 32'hDEADBEEF;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_hs2(input logic v, input string nm);
        for (int i = 0; i < 200; i++) begin
            if (uP_handshake_2 === v) return;
            @(negedge clk);
        end
        chk(nm, 40'(uP_handshake_2), 40'(v));
    endtask

    task automatic send_byte(input logic [7:0] b);
        uP_data_out = b;
        uP_handshake_1 = 1'b1;
        wait_hs2(1'b1, "rx_hs2_rise");
        uP_handshake_1 = 1'b0;
        wait_hs2(1'b0, "rx_hs2_fall");
    endtask

    task automatic recv_byte(output logic [7:0] b);
        wait_hs2(1'b1, "tx_hs2_rise");
        b = uP_data_in;
        uP_handshake_1 = 1'b1;
        wait_hs2(1'b0, "tx_hs2_fall");
        uP_handshake_1 = 1'b0;
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_hs2"}, 40'(uP_handshake_2), 40'd0);
        chk({nm, "_ack"}, 40'(uP_ack), 40'd0);
        chk({nm, "_wr"}, 40'(reg_write), 40'd0);
        chk({nm, "_rd"}, 40'(reg_read), 40'd0);
        chk({nm, "_din"}, 40'(uP_data_in), 40'd0);
        chk({nm, "_addr"}, 40'(reg_address), 40'd0);
        chk({nm, "_wdata"}, 40'(reg_write_data), 40'd0);
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int w0, r0;
        logic [7:0] b;
        w0 = wr_cnt;
        r0 = rd_cnt;
        rd_val = v.rval;
        uP_start = 1'b1;
        send_byte(v.cmd);
        send_byte(v.addr);
        for (int k = 0; k < 4; k++) send_byte(v.data[8*k +: 8]);
        for (int k = 0; k < v.nbytes; k++) begin
            recv_byte(b);
            chk($sformatf("v%0d_reply%0d", id, k), 40'(b), 40'(v.reply[8*k +: 8]));
        end
        for (int i = 0; i < 200 && uP_ack !== 1'b1; i++) @(negedge clk);
        chk($sformatf("v%0d_ack", id), 40'(uP_ack), 40'd1);
        chk($sformatf("v%0d_din_hold", id), 40'(uP_data_in), 40'(v.reply[8*(v.nbytes-1) +: 8]));
        chk($sformatf("v%0d_wr_pulses", id), 40'(wr_cnt - w0), 40'(v.nwr));
        chk($sformatf("v%0d_rd_pulses", id), 40'(rd_cnt - r0), 40'(v.nrd));
        if (v.nwr + v.nrd > 0) chk($sformatf("v%0d_addr", id), 40'(last_addr), 40'(v.addr));
        if (v.nwr > 0) chk($sformatf("v%0d_wdata", id), 40'(last_wdata), 40'(v.data));
        @(negedge clk);
        chk($sformatf("v%0d_ack_held", id), 40'(uP_ack), 40'd1);
        uP_start = 1'b0;
        repeat (LAT) @(negedge clk);
        chk($sformatf("v%0d_ack_clear", id), 40'(uP_ack), 40'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{8'h00, 8'd3,  32'h0507002A, 32'h0,        1, 0, 1, 40'h00};
        vecs[1] = '{8'h01, 8'd3,  32'h0,        32'h12345678, 0, 1, 5, 40'h0012345678};
        vecs[2] = '{8'h09, 8'd40, 32'h0,        32'h0,        0, 0, 1, 40'h01};
        vecs[3] = '{8'h00, 8'd40, 32'hCAFEF00D, 32'h0,        0, 0, 1, 40'h02};
        vecs[4] = '{8'h00, 8'd31, 32'hFFFFFFFF, 32'h0,        1, 0, 1, 40'h00};
        vecs[5] = '{8'h01, 8'd32, 32'h0,        32'h11111111, 0, 0, 1, 40'h02};
        vecs[6] = '{8'h80, 8'd0,  32'h0,        32'h0,        0, 0, 1, 40'h01};
        vecs[7] = '{8'h01, 8'd0,  32'h0,        32'hA5C30F81, 0, 1, 5, 40'h00A5C30F81};

        repeat (3) @(negedge clk);
        check_all_zero("in_reset");
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("after_reset");

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        begin : abort_seq
            int w0, r0;
            w0 = wr_cnt;
            r0 = rd_cnt;
            uP_start = 1'b1;
            send_byte(8'h00);
            send_byte(8'd3);
            send_byte(8'h2A);
            uP_data_out = 8'h11;
            uP_handshake_1 = 1'b1;
            wait_hs2(1'b1, "abort_hs2_rise");
            uP_start = 1'b0;
            repeat (LAT) @(negedge clk);
            chk("abort_hs2", 40'(uP_handshake_2), 40'd0);
            uP_handshake_1 = 1'b0;
            repeat (10) @(negedge clk);
            chk("abort_hs2_stays", 40'(uP_handshake_2), 40'd0);
            chk("abort_no_wr", 40'(wr_cnt - w0), 40'd0);
            chk("abort_no_rd", 40'(rd_cnt - r0), 40'd0);
            chk("abort_no_ack", 40'(uP_ack), 40'd0);
            run_vec(vecs[0], 100);
        end

        begin : reset_seq
            int w1, r1;
            logic [7:0] b;
            rd_val = 32'h12345678;
            uP_start = 1'b1;
            send_byte(8'h01);
            send_byte(8'd3);
            for (int k = 0; k < 4; k++) send_byte(8'h00);
            recv_byte(b);
            chk("rst_seq_byte0", 40'(b), 40'h78);
            wait_hs2(1'b1, "rst_seq_hs2_rise");
            chk("rst_seq_byte1_pre", 40'(uP_data_in), 40'h56);
            reset = 1'b1;
            uP_start = 1'b0;
            uP_handshake_1 = 1'b0;
            w1 = wr_cnt;
            r1 = rd_cnt;
            @(negedge clk);
            check_all_zero("mid_reset");
            reset = 1'b0;
            repeat (5) @(negedge clk);
            check_all_zero("post_mid_reset");
            chk("rst_no_wr", 40'(wr_cnt - w1), 40'd0);
            chk("rst_no_rd", 40'(rd_cnt - r1), 40'd0);
            run_vec(vecs[1], 101);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/up_bus_responder.md
UP_BUS_RESPONDER -- requirements
Module: up_bus_responder

Interface
REQ-001 Parameter NUM_REGS, default 32, number of valid register addresses; addresses 0..NUM_REGS-1 are legal.
REQ-002 clk  input  1  system clock (50 MHz).
REQ-003 reset  input  1  reset; one clock, synchronous and active-high.
REQ-004 uP_start  input  1  uP transaction request; high for the whole transaction.
REQ-005 uP_handshake_1  input  1  uP strobe: byte valid on receive, byte taken on reply.
REQ-006 uP_data_out  input  8  command byte from the uP.
REQ-007 uP_handshake_2  output  1  responder strobe: byte taken on receive, byte valid on reply.
REQ-008 uP_data_in  output  8  reply byte to the uP.
REQ-009 uP_ack  output  1  transaction complete.
REQ-010 reg_address  output  8  register number.
REQ-011 reg_write_data  output  32  write data.
REQ-012 reg_write  output  1  one-cycle write strobe.
REQ-013 reg_read  output  1  one-cycle read strobe.
REQ-014 reg_read_data  input  32  read data, valid exactly one cycle after reg_read.

Function
REQ-015 Packet from the uP shall be 6 bytes: command, register number, data0..data3 (data0 = LSB); data bytes are sent and ignored for reads.
REQ-016 Commands: 0x00 = write, 0x01 = read; any other value is illegal.
REQ-017 States: IDLE, RX_WAIT_H1, RX_WAIT_H1_LOW, EXECUTE, READ_WAIT, TX_LOAD, TX_WAIT_H1, TX_WAIT_H1_LOW, ACK.
REQ-018 IDLE -> RX_WAIT_H1 when uP_start = 1; byte index cleared.
REQ-019 RX_WAIT_H1: when uP_handshake_1 = 1, capture uP_data_out into slot[index]; set uP_handshake_2 = 1 on the next edge; go to RX_WAIT_H1_LOW.
REQ-020 RX_WAIT_H1_LOW: when uP_handshake_1 = 0, clear uP_handshake_2 on the next edge and increment the index; after slot 5 go to EXECUTE, otherwise go to RX_WAIT_H1.
REQ-021 EXECUTE lasts one cycle and drives reg_address = slot1.
- Write, legal address: reg_write = 1 for this cycle only; reg_write_data = {slot5, slot4, slot3, slot2}; status = 0x00; go to TX_LOAD.
- Read, legal address: reg_read = 1 for this cycle only; go to READ_WAIT.
- Illegal command: no strobe; status = 0x01.
- Legal command, slot1 >= NUM_REGS: no strobe; status = 0x02.
REQ-022 Illegal command takes precedence over an illegal address.
REQ-023 READ_WAIT lasts one cycle: latch reg_read_data and set status = 0x00.
REQ-024 Reply sequence: a successful read returns 5 bytes (data LSB first, then status); every other case returns 1 byte (status).
REQ-025 TX_LOAD drives uP_data_in with the next reply byte; uP_handshake_2 rises one cycle later (data is stable for at least 1 cycle before the strobe).
REQ-026 TX_WAIT_H1: when uP_handshake_1 = 1, clear uP_handshake_2.
REQ-027 TX_WAIT_H1_LOW: when uP_handshake_1 = 0, go to TX_LOAD if reply bytes remain, otherwise go to ACK.
REQ-028 ACK: uP_ack = 1 until uP_start = 0; then clear uP_ack and return to IDLE.
REQ-029 Abort: uP_start = 0 in any state other than IDLE or ACK shall return to IDLE on the next edge with uP_handshake_2 = 0; no register strobe is issued if the abort occurs before EXECUTE.
REQ-030 uP_data_in shall hold its last value outside TX states.

Reset
REQ-031 On reset the block shall enter IDLE and drive uP_handshake_2, uP_ack, reg_write, reg_read, uP_data_in, reg_address and reg_write_data to 0; the byte index shall be cleared.
REQ-032 Reset asserted mid-transaction shall take priority over all other events and issue no strobe in that cycle.

Configuration
REQ-033 Macro UP_INPUT_SYNC_EN defined: uP_start, uP_handshake_1 and uP_data_out pass through two-flop synchronisers before use, adding 2 cycles of latency to every input-driven transition.
REQ-034 Macro UP_INPUT_SYNC_EN undefined: the inputs are used directly (same-cycle sampling); the state sequence is otherwise identical.

Verification
REQ-035 Write packet 0,3,42,0,7,5 -> one reg_write pulse, reg_address = 3, data = 0x0507002A; reply byte 0x00; uP_ack high until uP_start drops.
REQ-036 Read packet 1,3,x,x,x,x with reg_read_data = 0x12345678 -> one reg_read pulse; reply 0x78, 0x56, 0x34, 0x12, 0x00; then uP_ack.
REQ-037 Command 9 to register 40 -> no strobes; single reply byte 0x01.
REQ-038 Write to register 40 with NUM_REGS = 32 -> no strobe; reply 0x02.
REQ-039 uP_start dropped after the third byte -> IDLE within 1 cycle (3 with sync), uP_handshake_2 = 0, no strobe; the next full packet completes normally.
REQ-040 Reset pulsed during the second reply byte -> all outputs 0 next cycle, IDLE, no strobe; run each scenario with and without UP_INPUT_SYNC_EN.
